// File: rtl/seq_detector_param.sv
// Runtime-configurable Moore sequence detector with registered match pulse.
// Optional saturating match counter enabled by defining SEQ_DET_CNT_EN.
module seq_detector_param #(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned LEN_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             x_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  output logic             z,
  output logic             busy,
  output logic [CNT_W-1:0] match_cnt
);

  localparam logic [1:0] S_FILL  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_MATCH = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;

  logic             accept;
  logic [PAT_W-1:0] hist_shift;
  logic [PAT_W-1:0] mask;
  logic             cmp;
  logic [LEN_W-1:0] fill_inc;
  logic [LEN_W-1:0] len_clamped;

  assign accept     = x_valid & ~cfg_load;
  assign hist_shift = {hist_q[PAT_W-2:0], x};
  assign fill_inc   = fill_q + 1'b1;

  // Only the low len bits of the history take part in the comparison.
  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len_q));
    end
  end

  assign cmp = (((hist_shift ^ pat_q) & mask) == '0);

  always_comb begin
    len_clamped = cfg_len;
    if (cfg_len == '0) begin
      len_clamped = LEN_W'(1);
    end else if (cfg_len > LEN_W'(PAT_W)) begin
      len_clamped = LEN_W'(PAT_W);
    end
  end

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    if (accept) begin
      hist_d = hist_shift;
    end
    case (state_q)
      S_FILL: begin
        if (accept) begin
          fill_d = fill_inc;
          if (fill_inc == len_q) begin
            state_d = cmp ? S_MATCH : S_ARMED;
          end
        end
      end
      S_ARMED: begin
        if (accept && cmp) begin
          state_d = S_MATCH;
        end
      end
      S_MATCH: begin
        if (ovl_q) begin
          state_d = (accept && cmp) ? S_MATCH : S_ARMED;
        end else if (accept) begin
          // Non-overlap: this bit starts a fresh fill, so len=1 completes immediately.
          fill_d = LEN_W'(1);
          if (len_q == LEN_W'(1)) begin
            state_d = cmp ? S_MATCH : S_ARMED;
          end else begin
            state_d = S_FILL;
          end
        end else begin
          fill_d  = '0;
          state_d = S_FILL;
        end
      end
      default: begin
        state_d = S_FILL;
        fill_d  = '0;
      end
    endcase
    if (cfg_load) begin
      state_d = S_FILL;
      hist_d  = '0;
      fill_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FILL;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= '0;
      len_q   <= LEN_W'(1);
      ovl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      if (cfg_load) begin
        pat_q <= cfg_pattern;
        len_q <= len_clamped;
        ovl_q <= cfg_overlap;
      end
    end
  end

  assign z    = (state_q == S_MATCH);
  assign busy = (state_q == S_FILL);

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || cfg_load) begin
      cnt_q <= '0;
    end else if ((state_d == S_MATCH) && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = {CNT_W{1'b0}};
`endif

endmodule
